// File: rtl/fir_pkg.sv
// Shared FIR output-path constants: datapath widths, clamp limits and drop counter width.
package fir_pkg;

  localparam int unsigned FIR_WIDTH_OUT   = 20;
  localparam int unsigned FIR_WIDTH_FINAL = 8;
  localparam int unsigned FIR_FRAC_SHIFT  = 8;
  localparam int unsigned FIR_FIFO_DEPTH  = 4;
  localparam int unsigned DROP_CNT_W      = 8;

  // Clamp limits of a signed w-bit sample.
  function automatic int final_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int final_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int FINAL_MAX = final_max(FIR_WIDTH_FINAL);
  localparam int FINAL_MIN = final_min(FIR_WIDTH_FINAL);

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is presented combinationally from the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop_c  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push_c = push & (~full | do_pop_c);
  assign rdata     = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push_c) wptr <= wptr + PW'(1);
      if (do_pop_c)  rptr <= rptr + PW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_buffer.sv
// Rounds and clamps FIR results, buffers them in a FIFO for a ready/valid consumer, and tracks saturation/drops.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH_OUT   = FIR_WIDTH_OUT,
  parameter int unsigned WIDTH_FINAL = FIR_WIDTH_FINAL,
  parameter int unsigned FRAC_SHIFT  = FIR_FRAC_SHIFT,
  parameter int unsigned FIFO_DEPTH  = FIR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH_OUT-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_FINAL-1:0] out_data,
  output logic                   sat_flag,
  output logic                   ovf_flag,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  input  logic                   flag_clr
);

  // One guard bit above the input so the rounding add cannot wrap.
  localparam int unsigned GW = WIDTH_OUT + 1;
  localparam logic signed [GW-1:0] RND    = GW'((1 << FRAC_SHIFT) >> 1);
  localparam logic signed [GW-1:0] SAT_HI = GW'(final_max(WIDTH_FINAL));
  localparam logic signed [GW-1:0] SAT_LO = GW'(final_min(WIDTH_FINAL));

  logic signed [GW-1:0]    ext_c;
  logic signed [GW-1:0]    rnd_c;
  logic signed [GW-1:0]    shf_c;
  logic [WIDTH_FINAL-1:0]  cond_c;
  logic                    clamp_c;

  logic                    s1_valid;
  logic [WIDTH_FINAL-1:0]  s1_data;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop_c;
  logic                    drop_c;
  logic                    sat_set_c;

  always_comb begin
    ext_c   = {in_data[WIDTH_OUT-1], in_data};
    rnd_c   = ext_c + RND;
    shf_c   = rnd_c >>> FRAC_SHIFT;
    clamp_c = 1'b0;
    cond_c  = shf_c[WIDTH_FINAL-1:0];
    if (shf_c > SAT_HI) begin
      clamp_c = 1'b1;
      cond_c  = SAT_HI[WIDTH_FINAL-1:0];
    end else if (shf_c < SAT_LO) begin
      clamp_c = 1'b1;
      cond_c  = SAT_LO[WIDTH_FINAL-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= cond_c;
    end
  end

  assign out_valid = ~fifo_empty;
  assign pop_c     = out_valid & out_ready;
  assign drop_c    = s1_valid & fifo_full & ~pop_c;
  assign sat_set_c = in_valid & clamp_c;

  sync_fifo #(
    .WIDTH (WIDTH_FINAL),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .pop   (pop_c),
    .wdata (s1_data),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Sticky status; a coincident set event beats flag_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sat_flag <= sat_set_c | (sat_flag & ~flag_clr);
      ovf_flag <= drop_c | (ovf_flag & ~flag_clr);
      if (drop_c) begin
        if (flag_clr)                       drop_cnt <= DROP_CNT_W'(1);
        else if (drop_cnt != DROP_CNT_MAX)  drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end else if (flag_clr) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Self-checking bench for fir_out_buffer against a queue-based behavioural model.
module tb_fir_out_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        sat_flag;
  logic        ovf_flag;
  logic [7:0]  drop_cnt;
  logic        flag_clr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] q[$];
  bit         m_s1_v;
  logic [7:0] m_s1_d;
  bit         m_sat;
  bit         m_ovf;
  int         m_drop;

  fir_out_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .drop_cnt  (drop_cnt),
    .flag_clr  (flag_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round half up by 2^8, then clamp to signed 8 bits.
  function automatic logic [8:0] cond(input logic [19:0] d);
    int x;
    int r;
    bit c;
    x = int'($signed(d));
    r = (x + 128) >>> 8;
    c = 0;
    if (r > 127)  begin r = 127;  c = 1; end
    if (r < -128) begin r = -128; c = 1; end
    return {c, 8'(r)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1_v = 0;
    m_s1_d = '0;
    m_sat  = 0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, return #1 later.
  task automatic drive(input bit v, input logic [19:0] d, input bit rdy, input bit clr);
    logic [8:0] cv;
    bit pop;
    bit drop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flag_clr  = clr;
    @(posedge clk);
    cv   = cond(d);
    pop  = (q.size() != 0) && rdy;
    drop = m_s1_v && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (m_s1_v && !drop) q.push_back(m_s1_d);
    m_sat = (v && cv[8]) || (m_sat && !clr);
    m_ovf = drop || (m_ovf && !clr);
    if (drop) m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    else if (clr) m_drop = 0;
    m_s1_v = v;
    if (v) m_s1_d = cv[7:0];
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, '0, rdy, 0);
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; out_ready = 0; flag_clr = 0;
    rst = 0;
    model_reset();
    #22;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if ({sat_flag, ovf_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {sat_flag, ovf_flag}); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    @(negedge clk);
    rst = 1;
    idle(1, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_no_push got %0b want 0", out_valid); end
  endtask

  task automatic test_rounding();
    drive(1, 20'h00180, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency1 got %0b want 0", out_valid); end
    idle(1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_latency2 got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL round_value got %h want 02", out_data); end
    idle(1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_pop got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    drive(1, 20'h7FFFF, 0, 0);
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got %0b want 1", sat_flag); end
    drive(1, 20'h80000, 0, 0);
    idle(1, 0);
    checks++; if (out_data !== 8'h7F) begin errors++; $display("FAIL sat_pos got %h want 7f", out_data); end
    idle(1, 1);
    checks++; if (out_data !== 8'h80) begin errors++; $display("FAIL sat_neg got %h want 80", out_data); end
    idle(1, 1);
    drive(0, '0, 0, 1);
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got %0b want 0", sat_flag); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 6; k++) drive(1, 20'(k * 256), 0, 0);
    idle(2, 0);
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf_flag); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (out_data !== 8'(k)) begin errors++; $display("FAIL ovf_order got %h want %h", out_data, 8'(k)); end
      idle(1, 1);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b want 0", out_valid); end
    drive(0, '0, 0, 1);
  endtask

  task automatic test_full_push_pop();
    drive(1, 20'(10 * 256), 0, 0);
    drive(1, 20'(11 * 256), 0, 0);
    drive(1, 20'(12 * 256), 0, 0);
    drive(1, 20'(13 * 256), 0, 0);
    drive(1, 20'(20 * 256), 0, 0);
    drive(0, '0, 1, 0);
    checks++; if (drop_cnt !== 8'd0 || ovf_flag !== 1'b0) begin errors++; $display("FAIL fullpp_no_drop got %0d/%0b want 0/0", drop_cnt, ovf_flag); end
    checks++; if (out_data !== 8'd11) begin errors++; $display("FAIL fullpp_head got %0d want 11", out_data); end
    idle(3, 1);
    checks++; if (out_data !== 8'd20) begin errors++; $display("FAIL fullpp_fourth got %0d want 20", out_data); end
    idle(1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpp_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_clr_with_drop();
    for (int k = 1; k <= 4; k++) drive(1, 20'(k * 256), 0, 0);
    drive(1, 20'(99 * 256), 0, 0);
    drive(0, '0, 0, 1);
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL clrdrop_ovf got %0b want 1", ovf_flag); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clrdrop_cnt got %0d want 1", drop_cnt); end
    idle(4, 1);
    drive(0, '0, 0, 1);
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 265; i++) drive(1, 20'h00100, 0, 0);
    idle(1, 0);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_cnt_sat got %0d want 255", drop_cnt); end
    idle(4, 1);
    drive(0, '0, 0, 1);
  endtask

  task automatic test_reset_mid();
    drive(1, 20'h7FFFF, 0, 0);
    drive(1, 20'(8 * 256), 0, 0);
    drive(1, 20'(9 * 256), 0, 0);
    idle(1, 0);
    checks++; if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0b/%0b want 1/1", out_valid, sat_flag); end
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
    checks++; if ({sat_flag, ovf_flag, drop_cnt} !== 10'd0) begin errors++; $display("FAIL rstmid_flags got %b want 0", {sat_flag, ovf_flag, drop_cnt}); end
    @(negedge clk);
    rst = 1;
    drive(1, 20'(5 * 256), 0, 0);
    idle(1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'd5) begin errors++; $display("FAIL rstmid_sample got %0b/%0d want 1/5", out_valid, out_data); end
    idle(1, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_alone got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [19:0] d;
    logic [7:0]  exp_d;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) d = 20'($urandom);
      else d = 20'($signed($urandom_range(0, 80000)) - 40000);
      drive(($urandom_range(0, 2) != 0), d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
      checks++;
      if (out_valid !== (q.size() != 0) || out_data !== exp_d) begin
        errors++; $display("FAIL rand_out cyc %0d got %0b/%h want %0b/%h", i, out_valid, out_data, (q.size() != 0), exp_d);
      end
      checks++;
      if (sat_flag !== m_sat || ovf_flag !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_flags cyc %0d got %0b/%0b/%0d want %0b/%0b/%0d", i, sat_flag, ovf_flag, drop_cnt, m_sat, m_ovf, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_clr_with_drop();
    test_drop_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_buffer.md
FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter WIDTH_OUT, 20, signed width of the accumulated FIR result consumed from the datapath.
REQ-002 Parameter WIDTH_FINAL, 8, signed width of the delivered output sample.
REQ-003 Parameter FRAC_SHIFT, 8, number of LSBs removed by rounding; range 0..WIDTH_OUT-WIDTH_FINAL.
REQ-004 Parameter FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  one-cycle pulse: in_data holds a completed FIR result.
REQ-008 in_data  input  WIDTH_OUT  signed FIR result (datapath FIR_output).
REQ-009 out_valid  output  1  FIFO head is valid.
REQ-010 out_ready  input  1  consumer accepts the head when out_valid=1.
REQ-011 out_data  output  WIDTH_FINAL  signed FIFO head.
REQ-012 sat_flag  output  1  sticky: at least one sample was saturated.
REQ-013 ovf_flag  output  1  sticky: at least one sample was dropped because the FIFO was full.
REQ-014 drop_cnt  output  8  number of dropped samples; saturates at 255.
REQ-015 flag_clr  input  1  synchronous clear of sat_flag, ovf_flag and drop_cnt.

Function
REQ-016 Conditioning SHALL add 2^(FRAC_SHIFT-1) (0 when FRAC_SHIFT=0), arithmetic-shift right by FRAC_SHIFT, then clamp to [-2^(WIDTH_FINAL-1), 2^(WIDTH_FINAL-1)-1]; intermediates carry one guard bit so the rounding add cannot wrap.
REQ-017 Stage 1 register (s1_valid, s1_data) SHALL capture the conditioned value on the edge where in_valid=1; s1_valid is 0 otherwise.
REQ-018 When s1_valid=1, a push SHALL write s1_data to the FIFO tail on the next edge, so out_valid rises two edges after the in_valid edge if the FIFO was empty.
REQ-019 A pop SHALL occur on any edge with out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL equal (count != 0), and out_data SHALL be driven from the registered head entry.
REQ-021 With push and pop on the same edge, count SHALL be unchanged and both SHALL take effect, including when count=FIFO_DEPTH.
REQ-022 A push with count=FIFO_DEPTH and no pop SHALL discard the sample, set ovf_flag, and increment drop_cnt (saturating).
REQ-023 sat_flag SHALL set on the edge where stage 1 captures a clamped value.
REQ-024 If flag_clr coincides with a new set event, the set SHALL win for that flag, and drop_cnt SHALL load 1 on a coincident drop.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL have range 0..FIFO_DEPTH.

Reset
REQ-026 When rst=0, the block SHALL immediately force s1_valid=0, pointers=0, count=0, out_valid=0, out_data=0, sat_flag=0, ovf_flag=0 and drop_cnt=0.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight samples; FIFO storage contents need not be cleared.
REQ-028 No push SHALL occur on the first edge after rst deasserts unless in_valid was sampled high on that edge into stage 1.

Structure
REQ-029 Conditioning min/max constants and the drop_cnt width SHALL reside in shared package fir_pkg, alongside the FIR width parameters.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH), and the conditioning stage SHALL stay inline.

Verification (defaults)
REQ-031 in_data=0x00180 with in_valid pulse -> out_data=0x02 (1.5 rounds to 2), out_valid rises 2 edges later.
REQ-032 in_data=0x7FFFF -> out_data=0x7F and sat_flag=1; in_data=0x80000 -> out_data=0x80.
REQ-033 out_ready=0, 6 pulses of values 1..6 (x256) -> FIFO holds 1..4, ovf_flag=1, drop_cnt=2; then out_ready=1 -> 1,2,3,4 delivered in order.
REQ-034 FIFO full, with a push and pop on the same edge -> count stays 4, no drop, new value appears 4th.
REQ-035 rst low while 3 entries are buffered -> out_valid=0 immediately, flags cleared, and the next sample after release arrives alone.
REQ-036 flag_clr asserted on the same edge as a drop -> ovf_flag stays 1 and drop_cnt=1.
